mode1_processor: RTL and testbench



---
 rtl/mode_pkg.sv | 34 +++
 rtl/mode1_processor_if.sv | 21 ++
 rtl/mode1_processor_tick_edge_detect.sv | 27 ++
 rtl/mode1_processor.sv | 48 ++++
 tb/tb_mode1_processor.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mode_pkg.sv
// Shared constants and types for the four-mode LED controller.
// Mode processors import this for LED width, step width and the fill/drain decode.
package mode_pkg;

  localparam int LED_W  = 8;
  localparam int STEP_W = 4;

  localparam logic [STEP_W-1:0] LAST_STEP     = STEP_W'(2 * LED_W - 1);
  localparam logic [LED_W-1:0]  LEDS_AT_STEP0 = {{(LED_W - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2,
    MODE4 = 2'd3
  } mode_e;

  // Steps 0..LED_W-1 fill from the LSB; steps LED_W..2*LED_W-1 drain from the LSB.
  function automatic logic [LED_W-1:0] decode_fill_drain(input logic [STEP_W-1:0] s);
    logic [LED_W-1:0] r;
    int si;
    r  = '0;
    si = int'(s);
    for (int i = 0; i < LED_W; i++) begin
      if (si < LED_W) begin
        r[i] = (i <= si);
      end else begin
        r[i] = (i >= si - LED_W + 1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mode1_processor_if.sv
// Step strobe, pause level and LED pattern between the controller and a mode processor.
interface mode1_processor_if;
  import mode_pkg::*;

  logic             tick;
  logic             pause;
  logic [LED_W-1:0] leds;

  modport master (
    output tick,
    output pause,
    input  leds
  );

  modport slave (
    input  tick,
    input  pause,
    output leds
  );

endinterface

// File: rtl/mode1_processor_tick_edge_detect.sv
// Rising-edge detector for the prescaler tick; shared by all mode processors.
module tick_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_d_q;
  logic in_d_d;

  always_comb begin
    in_d_d = in;
  end

  // Clearing to 0 makes a tick already high at reset release count as a rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_d_q <= 1'b0;
    end else begin
      in_d_q <= in_d_d;
    end
  end

  assign rise = in & ~in_d_q;

endmodule

// File: rtl/mode1_processor.sv
// Mode 1 pattern generator: a fill/drain LED bar advancing once per tick rise.
// The edge history keeps updating while paused, so a rise seen during pause is consumed.
module mode1_processor
  import mode_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  mode1_processor_if.slave   bus
);

  logic              tick_rise;
  logic              adv;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;
  logic [LED_W-1:0]  leds_q;
  logic [LED_W-1:0]  leds_d;

  tick_edge_detect u_tick_edge (
    .clk   (clk),
    .reset (reset),
    .in    (bus.tick),
    .rise  (tick_rise)
  );

  assign adv = tick_rise & ~bus.pause;

  // Decode the next step so leds moves on the same edge that samples the rise.
  always_comb begin
    step_d = step_q;
    if (adv) begin
      step_d = (step_q == LAST_STEP) ? '0 : step_q + STEP_W'(1);
    end
    leds_d = decode_fill_drain(step_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q <= '0;
      leds_q <= LEDS_AT_STEP0;
    end else begin
      step_q <= step_d;
      leds_q <= leds_d;
    end
  end

  assign bus.leds = leds_q;

endmodule

// File: tb/tb_mode1_processor.sv
// Directed self-checking bench for mode1_processor: reset, full run with wrap,
// pause, level tick, async reset mid-run, pause/tick coincidence and tick high at reset release.
module tb_mode1_processor;

  logic clk;
  logic reset;
  int   n_compared;
  int   n_mismatched;

  logic [7:0] fill_drain [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                  8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

  mode1_processor_if bus_if ();

  mode1_processor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // One 40 ns tick period: high for one clk, low for one clk; returns at a negedge.
  task automatic tick_pulse();
    @(negedge clk);
    bus_if.tick = 1'b1;
    @(negedge clk);
    bus_if.tick = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus_if.tick  = 1'b0;
    bus_if.pause = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_if.tick = ~bus_if.tick;
      n_compared++;
      if (bus_if.leds !== 8'h01) begin
        n_mismatched++;
        $display("[TB] FAIL reset_hold[%0d]: leds=%h expected %h", i, bus_if.leds, 8'h01);
      end
    end
    @(negedge clk);
    bus_if.tick = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    n_compared++;
    if (bus_if.leds !== 8'h01) begin
      n_mismatched++;
      $display("[TB] FAIL reset_release: leds=%h expected %h", bus_if.leds, 8'h01);
    end
  endtask

  task automatic test_run();
    for (int i = 1; i <= 16; i++) begin
      tick_pulse();
      n_compared++;
      if (bus_if.leds !== fill_drain[i % 16]) begin
        n_mismatched++;
        $display("[TB] FAIL run_step[%0d]: leds=%h expected %h", i, bus_if.leds, fill_drain[i % 16]);
      end
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i < 4; i++) tick_pulse();
    n_compared++;
    if (bus_if.leds !== 8'h1F) begin
      n_mismatched++;
      $display("[TB] FAIL pause_setup: leds=%h expected %h", bus_if.leds, 8'h1F);
    end
    bus_if.pause = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick_pulse();
      n_compared++;
      if (bus_if.leds !== 8'h1F) begin
        n_mismatched++;
        $display("[TB] FAIL pause_hold[%0d]: leds=%h expected %h", i, bus_if.leds, 8'h1F);
      end
    end
    bus_if.pause = 1'b0;
    @(negedge clk);
    n_compared++;
    if (bus_if.leds !== 8'h1F) begin
      n_mismatched++;
      $display("[TB] FAIL pause_release_idle: leds=%h expected %h", bus_if.leds, 8'h1F);
    end
    tick_pulse();
    n_compared++;
    if (bus_if.leds !== 8'h3F) begin
      n_mismatched++;
      $display("[TB] FAIL pause_resume: leds=%h expected %h", bus_if.leds, 8'h3F);
    end
  endtask

  task automatic test_level_tick();
    @(negedge clk);
    bus_if.tick = 1'b1;
    @(negedge clk);
    n_compared++;
    if (bus_if.leds !== 8'h7F) begin
      n_mismatched++;
      $display("[TB] FAIL level_first: leds=%h expected %h", bus_if.leds, 8'h7F);
    end
    for (int i = 0; i < 9; i++) @(negedge clk);
    n_compared++;
    if (bus_if.leds !== 8'h7F) begin
      n_mismatched++;
      $display("[TB] FAIL level_held: leds=%h expected %h", bus_if.leds, 8'h7F);
    end
    bus_if.tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_compared++;
    if (bus_if.leds !== 8'h7F) begin
      n_mismatched++;
      $display("[TB] FAIL level_low: leds=%h expected %h", bus_if.leds, 8'h7F);
    end
    bus_if.tick = 1'b1;
    @(negedge clk);
    n_compared++;
    if (bus_if.leds !== 8'hFF) begin
      n_mismatched++;
      $display("[TB] FAIL level_second: leds=%h expected %h", bus_if.leds, 8'hFF);
    end
    bus_if.tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) tick_pulse();
    n_compared++;
    if (bus_if.leds !== 8'hF0) begin
      n_mismatched++;
      $display("[TB] FAIL areset_setup: leds=%h expected %h", bus_if.leds, 8'hF0);
    end
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    n_compared++;
    if (bus_if.leds !== 8'h01) begin
      n_mismatched++;
      $display("[TB] FAIL areset_immediate: leds=%h expected %h", bus_if.leds, 8'h01);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_compared++;
    if (bus_if.leds !== 8'h01) begin
      n_mismatched++;
      $display("[TB] FAIL areset_release: leds=%h expected %h", bus_if.leds, 8'h01);
    end
    tick_pulse();
    n_compared++;
    if (bus_if.leds !== 8'h03) begin
      n_mismatched++;
      $display("[TB] FAIL areset_first_step: leds=%h expected %h", bus_if.leds, 8'h03);
    end
  endtask

  task automatic test_coincidence();
    @(negedge clk);
    bus_if.tick  = 1'b1;
    bus_if.pause = 1'b1;
    @(negedge clk);
    n_compared++;
    if (bus_if.leds !== 8'h03) begin
      n_mismatched++;
      $display("[TB] FAIL coinc_rise: leds=%h expected %h", bus_if.leds, 8'h03);
    end
    bus_if.pause = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_compared++;
    if (bus_if.leds !== 8'h03) begin
      n_mismatched++;
      $display("[TB] FAIL coinc_release_high: leds=%h expected %h", bus_if.leds, 8'h03);
    end
    bus_if.tick = 1'b0;
    bus_if.pause = 1'b1;
    @(negedge clk);
    bus_if.pause = 1'b0;
    @(negedge clk);
    n_compared++;
    if (bus_if.leds !== 8'h03) begin
      n_mismatched++;
      $display("[TB] FAIL coinc_pause_toggle: leds=%h expected %h", bus_if.leds, 8'h03);
    end
    tick_pulse();
    n_compared++;
    if (bus_if.leds !== 8'h07) begin
      n_mismatched++;
      $display("[TB] FAIL coinc_new_rise: leds=%h expected %h", bus_if.leds, 8'h07);
    end
  endtask

  task automatic test_tick_high_at_release();
    @(negedge clk);
    reset       = 1'b0;
    bus_if.tick = 1'b1;
    @(negedge clk);
    n_compared++;
    if (bus_if.leds !== 8'h01) begin
      n_mismatched++;
      $display("[TB] FAIL release_high_in_reset: leds=%h expected %h", bus_if.leds, 8'h01);
    end
    reset = 1'b1;
    @(negedge clk);
    n_compared++;
    if (bus_if.leds !== 8'h03) begin
      n_mismatched++;
      $display("[TB] FAIL release_high_step: leds=%h expected %h", bus_if.leds, 8'h03);
    end
    bus_if.tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_run();
    test_pause();
    test_level_tick();
    test_async_reset();
    test_coincidence();
    test_tick_high_at_release();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
